cpu_control_unit: RTL

Multi-cycle fetch/decode/execute controller directly upstream of the register-file-plus-ALU datapath. Fetches 16-bit instructions from an instruction memory over a valid handshake, holds them in an instruction register, and drives every datapath control input (register selects, write enable, add/sub, immediate select, LHI/LLI, OUT strobe). Latches the ALU N/Z/V/C flags and uses them to resolve conditional branches.

---
 rtl/cpu_ctrl_pkg.sv | 79 +++++++
 rtl/cpu_control_unit_instr_decoder.sv | 77 +++++++
 rtl/cpu_control_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu_control_unit slice: instruction field
// positions, opcode encodings, FSM state and branch-type enumerations, the
// decoded control bundle, and sign-extension helpers.
package cpu_ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned FLAG_W  = 4;

    // Instruction field bit positions
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 11;
    localparam int unsigned RD_MSB   = 10;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned RA_MSB   = 7;
    localparam int unsigned RA_LSB   = 5;
    localparam int unsigned RB_MSB   = 4;
    localparam int unsigned RB_LSB   = 2;
    localparam int unsigned IMM5_MSB = 4;
    localparam int unsigned IMM8_MSB = 7;

    // Z position inside the latched {N,Z,V,C} flag vector
    localparam int unsigned FLAG_Z = 2;

    // Opcodes
    localparam logic [OP_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUBI = 5'b00100;
    localparam logic [OP_W-1:0] OP_LHI  = 5'b00101;
    localparam logic [OP_W-1:0] OP_LLI  = 5'b00110;
    localparam logic [OP_W-1:0] OP_CMP  = 5'b00111;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b01000;
    localparam logic [OP_W-1:0] OP_B    = 5'b01001;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'b01010;
    localparam logic [OP_W-1:0] OP_BNE  = 5'b01011;
    localparam logic [OP_W-1:0] OP_HLT  = 5'b01111;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_ALWAYS = 2'd1,
        BR_EQ     = 2'd2,
        BR_NE     = 2'd3
    } br_t;

    // Decoded control bundle for the instruction held in ir
    typedef struct packed {
        logic               rf_we;
        logic               sub;
        logic               imm_sel;
        logic               lhi;
        logic               lli;
        logic               out_en;
        br_t                br;
        logic               flag_upd;
        logic               halt;
        logic               illegal;
        logic [REG_W-1:0]   rsel_a;
        logic [INSTR_W-1:0] ext_imm;
    } ctrl_t;

    function automatic logic [INSTR_W-1:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_control_unit_instr_decoder.sv
// instr_decoder: purely combinational translation of the instruction
// register into the control bundle used by cpu_control_unit.
// Ports:
//   ir   in  16       instruction register
//   ctrl out ctrl_t   write/sub/imm-select/LHI/LLI/out/branch/flag-update/
//                     halt/illegal, read-A select and extended immediate
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output ctrl_t              ctrl
);

    logic [OP_W-1:0] op;

    assign op = ir[OP_MSB:OP_LSB];

    // Opcode decode; anything not listed is flagged illegal and otherwise inert
    always_comb begin
        ctrl        = '0;
        ctrl.br     = BR_NONE;
        ctrl.rsel_a = ir[RA_MSB:RA_LSB];
        case (op)
            OP_NOP: begin
            end
            OP_ADD: begin
                ctrl.rf_we    = 1'b1;
                ctrl.flag_upd = 1'b1;
            end
            OP_SUB: begin
                ctrl.rf_we    = 1'b1;
                ctrl.sub      = 1'b1;
                ctrl.flag_upd = 1'b1;
            end
            OP_ADDI: begin
                ctrl.rf_we    = 1'b1;
                ctrl.imm_sel  = 1'b1;
                ctrl.flag_upd = 1'b1;
                ctrl.ext_imm  = sext5(ir[IMM5_MSB:0]);
            end
            OP_SUBI: begin
                ctrl.rf_we    = 1'b1;
                ctrl.sub      = 1'b1;
                ctrl.imm_sel  = 1'b1;
                ctrl.flag_upd = 1'b1;
                ctrl.ext_imm  = sext5(ir[IMM5_MSB:0]);
            end
            OP_LHI: begin
                // rd's low byte is merged back, so rd is also the read-A source
                ctrl.rf_we   = 1'b1;
                ctrl.imm_sel = 1'b1;
                ctrl.lhi     = 1'b1;
                ctrl.rsel_a  = ir[RD_MSB:RD_LSB];
                ctrl.ext_imm = {8'h00, ir[IMM8_MSB:0]};
            end
            OP_LLI: begin
                ctrl.rf_we   = 1'b1;
                ctrl.imm_sel = 1'b1;
                ctrl.lli     = 1'b1;
                ctrl.ext_imm = {8'h00, ir[IMM8_MSB:0]};
            end
            OP_CMP: begin
                ctrl.sub      = 1'b1;
                ctrl.flag_upd = 1'b1;
            end
            OP_OUT: begin
                ctrl.out_en = 1'b1;
            end
            OP_B:    ctrl.br = BR_ALWAYS;
            OP_BEQ:  ctrl.br = BR_EQ;
            OP_BNE:  ctrl.br = BR_NE;
            OP_HLT:  ctrl.halt = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FETCH -> DECODE -> EXEC controller for the
// register-file + ALU datapath. Latches ALU flags and resolves branches.
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into
// HALT (sticky illegal=1, pc held); otherwise they execute as NOP.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/imem_addr       fetch request (FETCH) and address (= pc)
//   imem_data/imem_valid     instruction word and its valid qualifier
//   N, Z, V, C               ALU flags from the datapath
//   RF_en, RF_addr           register write enable / write select
//   read_A, read_B           register read selects
//   add_or_sub, out_imm      ALU subtract, ALU B from ext_B_data
//   ext_B_data               extended immediate
//   LHI, LLI, ctro_outR      load-high/low select, output-register strobe
//   flags                    latched {N,Z,V,C}
//   halted, illegal          HALT state, sticky illegal-opcode indicator
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    input  logic               N,
    input  logic               Z,
    input  logic               V,
    input  logic               C,
    output logic               RF_en,
    output logic [REG_W-1:0]   RF_addr,
    output logic [REG_W-1:0]   read_A,
    output logic [REG_W-1:0]   read_B,
    output logic               add_or_sub,
    output logic               out_imm,
    output logic [INSTR_W-1:0] ext_B_data,
    output logic               LHI,
    output logic               LLI,
    output logic               ctro_outR,
    output logic [FLAG_W-1:0]  flags,
    output logic               halted,
    output logic               illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t              state, state_d;
    logic [PC_W-1:0]     pc, pc_d;
    logic [INSTR_W-1:0]  ir, ir_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                illegal_q, illegal_d;
    logic                br_take;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     br_off;
    ctrl_t               ctrl;

    instr_decoder u_dec (
        .ir   (ir),
        .ctrl (ctrl)
    );

    assign pc_inc    = pc + PC_W'(1);
    assign br_off    = PC_W'(sext8(ir[IMM8_MSB:0]));
    assign imem_addr = pc;
    assign flags     = flags_q;
    assign halted    = (state == ST_HALT);
    assign illegal   = illegal_q;

    // State and architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= '0;
            ir        <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, register updates and combinational control outputs
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        ir_d       = ir;
        flags_d    = flags_q;
        illegal_d  = illegal_q;
        br_take    = 1'b0;
        imem_req   = 1'b0;
        RF_en      = 1'b0;
        RF_addr    = '0;
        add_or_sub = 1'b0;
        out_imm    = 1'b0;
        ext_B_data = '0;
        LHI        = 1'b0;
        LLI        = 1'b0;
        ctro_outR  = 1'b0;
        // Read selects follow ir in every state so operands settle early
        read_A     = ctrl.rsel_a;
        read_B     = ir[RB_MSB:RB_LSB];

        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                RF_en      = ctrl.rf_we;
                RF_addr    = ir[RD_MSB:RD_LSB];
                add_or_sub = ctrl.sub;
                out_imm    = ctrl.imm_sel;
                ext_B_data = ctrl.ext_imm;
                LHI        = ctrl.lhi;
                LLI        = ctrl.lli;
                ctro_outR  = ctrl.out_en;

                if (ctrl.flag_upd) begin
                    flags_d = {N, Z, V, C};
                end

                // Branches test flags latched by earlier instructions
                case (ctrl.br)
                    BR_ALWAYS: br_take = 1'b1;
                    BR_EQ:     br_take = flags_q[FLAG_Z];
                    BR_NE:     br_take = ~flags_q[FLAG_Z];
                    default:   br_take = 1'b0;
                endcase

                state_d = ST_FETCH;
                pc_d    = br_take ? (pc_inc + br_off) : pc_inc;

                if (ctrl.halt) begin
                    state_d = ST_HALT;
                    pc_d    = pc;
                end

                if (TRAP_EN && ctrl.illegal) begin
                    state_d   = ST_HALT;
                    pc_d      = pc;
                    illegal_d = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule
